// File: rtl/dm_arb_pkg.sv
// Shared state encoding and sizing defaults for the two-master data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int AW_DEF     = 10;
  localparam int DW_DEF     = 32;
  localparam int WORD_BYTES = 4;
  // Address bits that must be zero for a word-aligned access.
  localparam int OFS_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/rr_pick2.sv
// Round-robin winner select for two requesters; purely combinational, no backpressure.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic any,
  output logic win,
  output logic next_last
);

  always_comb begin
    any = req0 | req1;
    // On a tie the master that did not win last time goes next.
    if (req0 && req1) win = ~last;
    else              win = req1;
    next_last = any ? win : last;
  end

endmodule

// File: rtl/dm_arb2.sv
// Two-master word arbiter for the data memory: 3 cycles per access (grant, ACC, RESP/ack).
// Requests wait (req held) while the other master is being served; misaligned accesses are suppressed.
module dm_arb2
  import dm_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  state_t        state, state_nxt;
  logic          last, sel, lat_we, bad;
  logic          any, win, next_last;
  logic [AW-1:0] g_addr;

  rr_pick2 u_pick (
    .req0      (m0_req),
    .req1      (m1_req),
    .last      (last),
    .any       (any),
    .win       (win),
    .next_last (next_last)
  );

  assign g_addr = win ? m1_addr : m0_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // mem_we and ack/err decode straight from state so reset kills them asynchronously.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    case (state)
      IDLE: if (any) state_nxt = ACC;
      ACC: begin
        mem_we    = lat_we & ~bad;
        state_nxt = RESP;
      end
      RESP: begin
        m0_ack    = ~sel;
        m1_ack    = sel;
        m0_err    = ~sel & bad;
        m1_err    = sel & bad;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= 1'b1;
      sel      <= 1'b0;
      lat_we   <= 1'b0;
      bad      <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else if (state == IDLE && any) begin
      last     <= next_last;
      sel      <= win;
      lat_we   <= win ? m1_we : m0_we;
      mem_addr <= g_addr;
      mem_din  <= win ? m1_wdata : m0_wdata;
      bad      <= |g_addr[OFS_W-1:0];
    end
  end

  // Read data lands at the end of ACC; writes leave the holding register alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == ACC && !lat_we) begin
      if (sel) m1_rdata <= bad ? '0 : mem_dout;
      else     m0_rdata <= bad ? '0 : mem_dout;
    end
  end

endmodule

// File: tb/tb_dm_arb2.sv
// Bench for dm_arb2: vector table, multi-cycle corner sequences and a random two-master run.
module tb_dm_arb2;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_we;

  int total = 0;
  int bad   = 0;
  bit mon_en;

  always #5 clk = ~clk;

  dm_arb2 #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 7 + 3) ^ (a >> 3));
  endfunction

  function automatic logic [31:0] init_word(input int a);
    return {init_byte(a + 3), init_byte(a + 2), init_byte(a + 1), init_byte(a)};
  endfunction

  // Byte-addressed memory attached to mem_*; filled on the first clock while reset is held.
  logic [7:0] hm [0:(1<<AW)-1];
  bit         hm_init;
  always @(posedge clk) begin
    if (!hm_init) begin
      for (int i = 0; i < (1 << AW); i++) hm[i] <= init_byte(i);
      hm_init <= 1'b1;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++) hm[AW'(mem_addr + AW'(i))] <= mem_din[8*i +: 8];
    end
  end
  always_comb mem_dout = {hm[mem_addr + 10'd3], hm[mem_addr + 10'd2], hm[mem_addr + 10'd1], hm[mem_addr]};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    chk("one_ack", m0_ack & m1_ack, 0);
    chk("err_wo_ack", (m0_err & ~m0_ack) | (m1_err & ~m1_ack), 0);
  end

  task automatic drive(input int m, input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  function automatic logic get_ack(input int m);  return m ? m1_ack : m0_ack;  endfunction
  function automatic logic get_err(input int m);  return m ? m1_err : m0_err;  endfunction
  function automatic logic [DW-1:0] get_rdata(input int m); return m ? m1_rdata : m0_rdata; endfunction

  typedef struct {
    int            m;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t          vt [9];
  logic [DW-1:0] hold [2];
  logic [31:0]   ref_mem [0:(1<<(AW-2))-1];

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.m, 1'b1, v.we, v.addr, v.wdata);
    @(negedge clk);
    chk("acc_we", mem_we, v.we & ~v.exp_err);
    chk("acc_addr", mem_addr, v.addr);
    if (v.we) chk("acc_din", mem_din, v.wdata);
    chk("acc_noack", m0_ack | m1_ack, 0);
    @(negedge clk);
    chk("resp_ack", {m1_ack, m0_ack}, v.m ? 2'b10 : 2'b01);
    chk("resp_err", get_err(v.m), v.exp_err);
    chk("resp_rdata", get_rdata(v.m), v.exp_rdata);
    chk("resp_other_rdata", get_rdata(1 - v.m), hold[1 - v.m]);
    chk("resp_we", mem_we, 0);
    drive(v.m, 1'b0, 1'b0, '0, '0);
    hold[v.m] = v.exp_rdata;
    if (v.we && !v.exp_err) ref_mem[v.addr[AW-1:2]] = v.wdata;
  endtask

  // Acks expected every 3 cycles starting 2 cycles after the request edge; optional alternation.
  task automatic watch_acks(input int n_acks, input int first_m, input logic alt,
                            input logic [DW-1:0] e0, input logic [DW-1:0] e1, input string nm);
    int m;
    int nlast;
    m = first_m;
    nlast = 2 + 3 * (n_acks - 1);
    for (int n = 1; n <= nlast; n++) begin
      @(negedge clk);
      if (n >= 2 && (n - 2) % 3 == 0) begin
        chk({nm, "_ack"}, {m1_ack, m0_ack}, m ? 2'b10 : 2'b01);
        chk({nm, "_rdata"}, get_rdata(m), m ? e1 : e0);
        if (alt) m = 1 - m;
      end else begin
        chk({nm, "_gap"}, {m1_ack, m0_ack}, 2'b00);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  int            outst [2];
  logic          r_we [2];
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_wd [2];
  int            wait_c [2];
  int            oth [2];
  logic          misal;
  logic [DW-1:0] exp_rd;

  initial begin
    vt[0] = '{0, 1'b1, 10'h010, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1] = '{0, 1'b0, 10'h010, 32'h0,        1'b0, 32'hDEADBEEF};
    vt[2] = '{1, 1'b1, 10'h102, 32'h12345678, 1'b1, 32'h0};
    vt[3] = '{1, 1'b0, 10'h100, 32'h0,        1'b0, init_word(32'h100)};
    vt[4] = '{1, 1'b1, 10'h3FC, 32'hA5A5A5A5, 1'b0, init_word(32'h100)};
    vt[5] = '{1, 1'b0, 10'h3FC, 32'h0,        1'b0, 32'hA5A5A5A5};
    vt[6] = '{0, 1'b0, 10'h011, 32'h0,        1'b1, 32'h0};
    vt[7] = '{0, 1'b1, 10'h020, 32'h0BADF00D, 1'b0, 32'h0};
    vt[8] = '{0, 1'b0, 10'h020, 32'h0,        1'b0, 32'h0BADF00D};
    for (int i = 0; i < (1 << (AW - 2)); i++) ref_mem[i] = init_word(4 * i);
    hold[0] = '0;
    hold[1] = '0;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", {m1_ack, m0_ack}, 0);
    chk("rst_err", {m1_err, m0_err}, 0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
    chk("rst_mem", {mem_we, mem_addr, mem_din}, 0);
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    // Reset during the ACC cycle of a write.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 10'h020, 32'h11112222);
    @(negedge clk);
    chk("rst_acc_we_pre", mem_we, 1);
    rst = 1'b1;
    #1;
    chk("rst_acc_we_drop", mem_we, 0);
    chk("rst_acc_noack", {m1_ack, m0_ack}, 0);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_ack_err", {m1_ack, m0_ack, m1_err, m0_err}, 0);
    chk("rst2_rdata", {m1_rdata, m0_rdata}, 0);
    chk("rst2_mem", {mem_we, mem_addr, mem_din}, 0);
    hold[0] = '0;
    hold[1] = '0;

    // Tie straight after reset, then continuous alternation; the aborted write left 0x020 intact.
    drive(0, 1'b1, 1'b0, 10'h020, '0);
    drive(1, 1'b1, 1'b0, 10'h3FC, '0);
    watch_acks(10, 0, 1'b1, 32'h0BADF00D, 32'hA5A5A5A5, "tie");
    hold[0] = 32'h0BADF00D;
    hold[1] = 32'hA5A5A5A5;

    // Single master holding req through ack: back-to-back transactions 3 cycles apart.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 10'h010, '0);
    watch_acks(2, 0, 1'b0, 32'hDEADBEEF, '0, "hold");
    hold[0] = 32'hDEADBEEF;

    // Random traffic against a transaction-level model.
    outst[0] = 0; outst[1] = 0;
    for (int cyc = 0; cyc < 3040; cyc++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (get_ack(m)) begin
          if (outst[m] == 0) begin
            chk("rnd_spurious_ack", 1, 0);
          end else begin
            misal = |r_addr[m][1:0];
            chk("rnd_err", get_err(m), misal);
            if (r_we[m])    exp_rd = hold[m];
            else if (misal) exp_rd = '0;
            else            exp_rd = ref_mem[r_addr[m][AW-1:2]];
            chk("rnd_rdata", get_rdata(m), exp_rd);
            chk("rnd_fair", oth[m] <= 1, 1);
            hold[m] = exp_rd;
            if (r_we[m] && !misal) ref_mem[r_addr[m][AW-1:2]] = r_wd[m];
            outst[m] = 0;
            if (outst[1 - m] != 0) oth[1 - m]++;
            drive(m, 1'b0, 1'b0, '0, '0);
          end
        end else begin
          chk("rnd_hold", get_rdata(m), hold[m]);
          if (outst[m] != 0) begin
            wait_c[m]++;
            if (wait_c[m] > 12) begin
              chk("rnd_timeout", wait_c[m], 12);
              outst[m] = 0;
              drive(m, 1'b0, 1'b0, '0, '0);
            end
          end
        end
      end
      if (cyc < 3000) begin
        for (int m = 0; m < 2; m++) begin
          if (outst[m] == 0 && $urandom_range(0, 2) == 0) begin
            r_we[m]   = 1'($urandom_range(0, 1));
            r_addr[m] = {8'($urandom), 2'b00};
            if ($urandom_range(0, 5) == 0) r_addr[m][1:0] = 2'($urandom_range(1, 3));
            r_wd[m]   = $urandom;
            outst[m]  = 1;
            wait_c[m] = 0;
            oth[m]    = 0;
            drive(m, 1'b1, r_we[m], r_addr[m], r_wd[m]);
          end
        end
      end
    end
    chk("rnd_drain", outst[0] | outst[1], 0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
